// File: rtl/parking_gate_ctrl.sv
// Entry-barrier sequencer with a saturating occupancy counter for the parking lot.
// Define PARKING_GATE_TIMEOUT_EN to close the gate automatically after OPEN_TO idle cycles.
module parking_gate_ctrl #(
   parameter int CAPACITY   = 16,
   parameter int CNT_W      = 5,
   parameter int OPEN_TO    = 255,
   parameter int CLOSE_HOLD = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             entry_req,
   input  logic             car_in,
   input  logic             car_out,
   output logic             gate_open,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OPEN  = 2'd1,
      CLOSE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAPACITY);
   localparam logic [7:0]       OPEN_LAST = 8'(OPEN_TO - 1);
   localparam logic [7:0]       HOLD_LAST = 8'(CLOSE_HOLD - 1);

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       timer;
   logic [7:0]       timer_nxt;
   logic             timeout_nxt;
   logic [CNT_W-1:0] count_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         timer   <= 8'd0;
         timeout <= 1'b0;
         count   <= '0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         timeout <= timeout_nxt;
         count   <= count_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (entry_req && !full) begin
               state_nxt = OPEN;
               timer_nxt = 8'd0;
            end
         end
         OPEN: begin
            if (car_in) begin
               state_nxt = CLOSE;
               timer_nxt = 8'd0;
            end
`ifdef PARKING_GATE_TIMEOUT_EN
            else if (timer == OPEN_LAST) begin
               state_nxt   = CLOSE;
               timer_nxt   = 8'd0;
               timeout_nxt = 1'b1;
            end else begin
               timer_nxt = timer + 8'd1;
            end
`endif
         end
         CLOSE: begin
            timer_nxt = timer + 8'd1;
            if (timer == HOLD_LAST) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            timer_nxt = 8'd0;
         end
      endcase
   end

`ifndef PARKING_GATE_TIMEOUT_EN
   logic unused_open_to;
   assign unused_open_to = ^OPEN_LAST;
`endif

   // Counted every cycle so cars slipping in behind an open gate are still tracked.
   always_comb begin
      count_nxt = count;
      if (car_in && !car_out && count != CAP_C) begin
         count_nxt = count + CNT_W'(1);
      end else if (car_out && !car_in && count != '0) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   assign gate_open = (state == OPEN);
   assign full      = (count == CAP_C);
   assign empty     = (count == '0);

endmodule
